serial_mem_responder: RTL
=========================

Name: serial_mem_responder

Overview:
- Far end of the console's 2-bit serial memory link, used in the bench harness and the FPGA companion.
- Decodes request frames arriving on the console's tx_pins (uio_out[5:4]) and executes them against a synchronous external memory port.
- Returns read data as frames on the console's rx_pins (uio_in[7:6]).
- One outstanding request at a time; fully synchronous; no combinational paths from inputs to outputs.

Parameters:
ADDR_BITS, 16, request address width; must be even.
DATA_BITS, 16, data word width; must be even.
RESP_DELAY, 2, extra idle cycles between memory data capture and response start symbol; 0 allowed.

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
tx_pins  in  2  console-to-responder symbols, sampled every posedge
rx_pins  out  2  responder-to-console symbols, registered
mem_rd  out  1  one-cycle read strobe
mem_we  out  1  one-cycle write strobe
mem_addr  out  ADDR_BITS  memory address, valid with mem_rd/mem_we
mem_wdata  out  DATA_BITS  write data, valid with mem_we
mem_rdata  in  DATA_BITS  read data, valid exactly 1 cycle after mem_rd
busy  out  1  high from start-symbol acceptance until frame fully handled
protocol_err  out  1  sticky error flag; cleared only by reset

Behaviour:
- Reset: clk and rst_n as already decided (reset rst_n, synchronous, active-low; clock clk). Reset forces FSM=IDLE and all outputs to 0 (rx_pins=00, strobes=0, mem_addr=0, mem_wdata=0, busy=0, protocol_err=0). Reset mid-frame or mid-response abandons the operation; rx_pins=00 the cycle after reset.
- Symbols: 2 bits per cycle, LSB-first. Fields are ADDR_BITS/2 or DATA_BITS/2 symbols. tx idle value is 00.
- Start symbol, sampled in IDLE, defines edge 0:
  - 01 = read, 10 = write.
  - 11 = reserved: set protocol_err and stay IDLE; following symbols are treated as new start candidates.
- FSM states: IDLE, RX_ADDR, RX_DATA, MEM_RD, MEM_CAP, DELAY, TX_START, TX_DATA, WR.
- Read (ADDR_BITS=16, RESP_DELAY=D):
  - Address symbols sampled at edges 1..8.
  - mem_rd=1 and mem_addr valid in the cycle after edge 8.
  - mem_rdata captured at edge 10.
  - rx_pins=01 (start) for one cycle beginning after edge 10+D.
  - Data symbols driven after edges 11+D..18+D.
  - rx_pins=00 and busy=0 after edge 19+D. A start symbol sampled at edge 19+D or later is accepted.
- Write:
  - Address symbols at edges 1..8, data symbols at edges 9..16.
  - mem_we=1 with mem_addr and mem_wdata for exactly one cycle after edge 16.
  - No response frame.
  - busy=0 after edge 17; a start symbol at edge 17 is accepted (back-to-back).
- Non-idle tx symbols while busy, other than frame payload (e.g., during MEM_RD..TX_DATA): ignored; protocol_err set; the current operation completes unaffected.
- mem_addr and mem_wdata hold their last values when strobes are low. mem_rd and mem_we are never high together.
- busy=1 from the cycle after edge 0 through the final cycle of the frame/response.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with tx_pins=11 -> all outputs 0, protocol_err=0, busy=0.
- Read, D=2: send start 01 then addr 0x1234 (00,01,11,00,10,00,01,00); model returns 0xBEEF -> mem_rd pulses once with mem_addr=0x1234; rx_pins=01 after edge 12, then 11,11,10,11,10,11,11,10; then 00.
- Write: send start 10, addr 0x00FF, data 0xA5A5 -> single mem_we cycle after edge 16 with mem_addr=0x00FF, mem_wdata=0xA5A5; rx_pins stays 00; protocol_err=0.
- Back-to-back: write frame immediately followed at edge 17 by a read of 0x00FF (D=0) -> both execute; read returns 0xA5A5 starting after edge 27.
- Collision and reserved: tx=01 during TX_DATA -> response unchanged, protocol_err=1. Separately, after reset, tx=11 -> protocol_err=1, busy stays 0.
- Reset mid-response: assert rst_n=0 during the 3rd data symbol -> rx_pins=00 the next cycle; a subsequent read completes correctly.

Source files
------------

// File: rtl/serial_mem_responder.sv
// ============================================================================
//  Module   : serial_mem_responder
//  Brief    : Far end of the 2-bit serial memory link. Decodes request frames,
//             executes them on a synchronous memory port, returns read data.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_mem_responder #(
    parameter int ADDR_BITS  = 16,
    parameter int DATA_BITS  = 16,
    parameter int RESP_DELAY = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           tx_pins,
    output logic [1:0]           rx_pins,
    output logic                 mem_rd,
    output logic                 mem_we,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [DATA_BITS-1:0] mem_wdata,
    input  logic [DATA_BITS-1:0] mem_rdata,
    output logic                 busy,
    output logic                 protocol_err
);

    localparam int ADDR_SYMS = ADDR_BITS / 2;
    localparam int DATA_SYMS = DATA_BITS / 2;
    localparam int MAX_FLD   = (ADDR_SYMS > DATA_SYMS) ? ADDR_SYMS : DATA_SYMS;
    localparam int MAX_CNT   = (MAX_FLD > RESP_DELAY) ? MAX_FLD : RESP_DELAY;
    localparam int CNT_W     = $clog2(MAX_CNT + 1);

    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_SYMS - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_SYMS - 1);
    localparam logic [CNT_W-1:0] DLY_LAST  = CNT_W'((RESP_DELAY > 0) ? RESP_DELAY - 1 : 0);

    localparam logic [1:0] SYM_IDLE  = 2'b00;
    localparam logic [1:0] SYM_READ  = 2'b01;
    localparam logic [1:0] SYM_WRITE = 2'b10;
    localparam logic [1:0] SYM_RSVD  = 2'b11;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        RX_ADDR  = 4'd1,
        RX_DATA  = 4'd2,
        MEM_RD   = 4'd3,
        MEM_CAP  = 4'd4,
        DELAY    = 4'd5,
        TX_START = 4'd6,
        TX_DATA  = 4'd7,
        WR       = 4'd8
    } state_t;

    state_t               state_q, state_d;
    logic                 is_write_q, is_write_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ADDR_BITS-1:0] addr_sr_q, addr_sr_d;
    logic [DATA_BITS-1:0] data_sr_q, data_sr_d;
    logic [ADDR_BITS-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_BITS-1:0] mem_wdata_q, mem_wdata_d;
    logic                 mem_rd_q, mem_rd_d;
    logic                 mem_we_q, mem_we_d;
    logic [1:0]           rx_q, rx_d;
    logic                 busy_q, busy_d;
    logic                 err_q, err_d;
    logic                 accept_start;
    logic                 stray_sym;

    assign stray_sym = (tx_pins != SYM_IDLE);

    always_comb begin
        state_d      = state_q;
        is_write_d   = is_write_q;
        cnt_d        = cnt_q;
        addr_sr_d    = addr_sr_q;
        data_sr_d    = data_sr_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_rd_d     = 1'b0;
        mem_we_d     = 1'b0;
        rx_d         = rx_q;
        busy_d       = busy_q;
        err_d        = err_q;
        accept_start = 1'b0;

        case (state_q)
            IDLE: begin
                accept_start = 1'b1;
            end

            RX_ADDR: begin
                addr_sr_d = {tx_pins, addr_sr_q[ADDR_BITS-1:2]};
                if (cnt_q == ADDR_LAST) begin
                    cnt_d = '0;
                    if (is_write_q) begin
                        state_d = RX_DATA;
                    end else begin
                        state_d    = MEM_RD;
                        mem_rd_d   = 1'b1;
                        mem_addr_d = addr_sr_d;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            RX_DATA: begin
                data_sr_d = {tx_pins, data_sr_q[DATA_BITS-1:2]};
                if (cnt_q == DATA_LAST) begin
                    cnt_d       = '0;
                    state_d     = WR;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = addr_sr_q;
                    mem_wdata_d = data_sr_d;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            // Memory samples the strobe on this edge; data arrives one cycle later.
            MEM_RD: begin
                if (stray_sym) err_d = 1'b1;
                state_d = MEM_CAP;
            end

            MEM_CAP: begin
                if (stray_sym) err_d = 1'b1;
                data_sr_d = mem_rdata;
                cnt_d     = '0;
                if (RESP_DELAY == 0) begin
                    state_d = TX_START;
                    rx_d    = SYM_READ;
                end else begin
                    state_d = DELAY;
                end
            end

            DELAY: begin
                if (stray_sym) err_d = 1'b1;
                if (cnt_q == DLY_LAST) begin
                    cnt_d   = '0;
                    state_d = TX_START;
                    rx_d    = SYM_READ;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            TX_START: begin
                if (stray_sym) err_d = 1'b1;
                rx_d      = data_sr_q[1:0];
                data_sr_d = {2'b00, data_sr_q[DATA_BITS-1:2]};
                cnt_d     = '0;
                state_d   = TX_DATA;
            end

            // The edge ending the last data symbol doubles as an idle sample.
            TX_DATA: begin
                if (cnt_q == DATA_LAST) begin
                    rx_d         = SYM_IDLE;
                    busy_d       = 1'b0;
                    cnt_d        = '0;
                    state_d      = IDLE;
                    accept_start = 1'b1;
                end else begin
                    if (stray_sym) err_d = 1'b1;
                    rx_d      = data_sr_q[1:0];
                    data_sr_d = {2'b00, data_sr_q[DATA_BITS-1:2]};
                    cnt_d     = cnt_q + 1'b1;
                end
            end

            WR: begin
                busy_d       = 1'b0;
                state_d      = IDLE;
                accept_start = 1'b1;
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                rx_d    = SYM_IDLE;
            end
        endcase

        if (accept_start) begin
            case (tx_pins)
                SYM_READ: begin
                    state_d    = RX_ADDR;
                    is_write_d = 1'b0;
                    busy_d     = 1'b1;
                    cnt_d      = '0;
                end
                SYM_WRITE: begin
                    state_d    = RX_ADDR;
                    is_write_d = 1'b1;
                    busy_d     = 1'b1;
                    cnt_d      = '0;
                end
                SYM_RSVD: begin
                    err_d = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            is_write_q  <= 1'b0;
            cnt_q       <= '0;
            addr_sr_q   <= '0;
            data_sr_q   <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_rd_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            rx_q        <= 2'b00;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            is_write_q  <= is_write_d;
            cnt_q       <= cnt_d;
            addr_sr_q   <= addr_sr_d;
            data_sr_q   <= data_sr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_rd_q    <= mem_rd_d;
            mem_we_q    <= mem_we_d;
            rx_q        <= rx_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    assign rx_pins      = rx_q;
    assign mem_rd       = mem_rd_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign busy         = busy_q;
    assign protocol_err = err_q;

endmodule

`default_nettype wire
